// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 raster constants and helpers
// for the VGA timing path.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_CLK_DIV = 4;
    localparam int DEF_H_DISP  = 640;
    localparam int DEF_H_FP    = 16;
    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_H_BP    = 48;
    localparam int DEF_V_DISP  = 480;
    localparam int DEF_V_FP    = 10;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_V_BP    = 33;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t lo;
        coord_t hi;
    } sync_range_t;

    function automatic int span(
        input int disp,
        input int fp,
        input int sync,
        input int bp
    );
        return disp + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL =
        span(DEF_H_DISP, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL =
        span(DEF_V_DISP, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    // Sync pulse occupies the slots right after the front porch.
    function automatic sync_range_t sync_range(
        input int disp,
        input int fp,
        input int sync
    );
        sync_range_t r;
        r.lo = coord_t'(disp + fp);
        r.hi = coord_t'(disp + fp + sync - 1);
        return r;
    endfunction

endpackage

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// pixel_tick_gen: divides the system clock into a one-clk
// pixel enable every CLK_DIV clocks.
module pixel_tick_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    always_comb begin
        div_d = div_q + DW'(1);
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign p_tick = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster counters, registered sync pins and
// blanking/coordinate decodes for the VGA display path.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int H_DISP      = DEF_H_DISP,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_DISP      = DEF_V_DISP,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int SYNC_ACTIVE = 0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               p_tick,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               frame_start
);

    localparam int H_TOTAL = span(H_DISP, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span(V_DISP, V_FP, V_SYNC, V_BP);

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS  = coord_t'(H_DISP);
    localparam coord_t V_VIS  = coord_t'(V_DISP);

    localparam sync_range_t HS = sync_range(H_DISP, H_FP, H_SYNC);
    localparam sync_range_t VS = sync_range(V_DISP, V_FP, V_SYNC);

    localparam logic SYNC_ON  = (SYNC_ACTIVE != 0);
    localparam logic SYNC_OFF = !SYNC_ON;

    logic   tick;
    logic   line_end;
    logic   frame_end;
    coord_t h_q, h_d;
    coord_t v_q, v_d;
    logic   hs_q, hs_d;
    logic   vs_q, vs_d;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .p_tick (tick)
    );

    assign line_end  = (h_q == H_LAST);
    assign frame_end = line_end && (v_q == V_LAST);

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (tick) begin
            h_d = line_end ? '0 : h_q + coord_t'(1);
            if (line_end) begin
                v_d = frame_end ? '0 : v_q + coord_t'(1);
            end
        end
    end

    // Syncs follow the next-state counters so they land on the
    // same edge as the coordinates they belong to.
    always_comb begin
        hs_d = SYNC_OFF;
        vs_d = SYNC_OFF;
        if (h_d >= HS.lo && h_d <= HS.hi) begin
            hs_d = SYNC_ON;
        end
        if (v_d >= VS.lo && v_d <= VS.hi) begin
            vs_d = SYNC_ON;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q  <= '0;
            v_q  <= '0;
            hs_q <= SYNC_OFF;
            vs_q <= SYNC_OFF;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
        end
    end

    assign p_tick      = tick;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign pixel_x     = h_q;
    assign pixel_y     = v_q;
    assign video_on    = (h_q < H_VIS) && (v_q < V_VIS);
    assign frame_start = tick && frame_end;

endmodule
